// File: rtl/mem_io_responder_pkg.sv
// Shared constants and decode helpers for the CPU I/O window responder.
package mem_io_responder_pkg;

  localparam int          BYTE_BUS_W  = 8;
  localparam logic [17:0] IO_BASE     = 18'h30000;
  localparam logic [2:0]  OFS_CONSOLE = 3'd0;
  localparam logic [2:0]  OFS_COUNTER = 3'd4;

  typedef enum logic [1:0] {
    PORT_NONE,
    PORT_CONSOLE,
    PORT_COUNTER
  } io_port_e;

  // Bits [15:3] are ignored, so every I/O address aliases onto one of the two ports.
  function automatic io_port_e decode_port(input logic [17:0] a);
    io_port_e port;
    port = PORT_NONE;
    if (a[17:16] == IO_BASE[17:16]) begin
      case (a[2:0] & 3'b100)
        OFS_CONSOLE: port = PORT_CONSOLE;
        OFS_COUNTER: port = PORT_COUNTER;
        default:     port = PORT_NONE;
      endcase
    end
    return port;
  endfunction

  function automatic logic [7:0] dword_byte(input logic [31:0] d, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU byte bus plus UART stream signals seen by the I/O responder.
interface mem_io_responder_if;
  import mem_io_responder_pkg::*;

  logic [17:0]           cpu_a;
  logic                  cpu_wr;
  logic [BYTE_BUS_W-1:0] cpu_dout;
  logic [BYTE_BUS_W-1:0] cpu_din;
  logic                  cpu_rdy;
  logic                  io_sel_q;
  logic                  rx_valid;
  logic [BYTE_BUS_W-1:0] rx_data;
  logic                  rx_ready;
  logic                  tx_valid;
  logic [BYTE_BUS_W-1:0] tx_data;
  logic                  tx_ready;
  logic                  halt;

  modport slave (
    input  cpu_a, cpu_wr, cpu_dout, rx_valid, rx_data, tx_ready,
    output cpu_din, cpu_rdy, io_sel_q, rx_ready, tx_valid, tx_data, halt
  );

  modport master (
    output cpu_a, cpu_wr, cpu_dout, rx_valid, rx_data, tx_ready,
    input  cpu_din, cpu_rdy, io_sel_q, rx_ready, tx_valid, tx_data, halt
  );

endinterface

// File: rtl/mem_io_responder_fifo_sync.sv
// Single-clock FIFO; head reads as zero while empty so idle outputs are clean.
module fifo_sync #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  logic [W-1:0] r_mem [0:(1<<AW)-1];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/mem_io_responder.sv
// I/O window responder: console RX/TX FIFOs, cycle counter with coherent
// dword snapshot, sticky program-stop flag and TX-full back-pressure.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int FIFO_AW = 3,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  mem_io_responder_if.slave  bus
);

  io_port_e              w_port;
  logic                  w_rd;
  logic                  w_wr_req;
  logic                  w_tx_push_req;
  logic [BYTE_BUS_W-1:0] w_tx_din;
  logic                  w_tx_push;
  logic                  w_tx_pop;
  logic                  w_tx_full;
  logic                  w_tx_empty;
  logic [BYTE_BUS_W-1:0] w_tx_head;
  logic                  w_stall;
  logic                  w_rx_push;
  logic                  w_rx_pop;
  logic                  w_rx_full;
  logic                  w_rx_empty;
  logic [BYTE_BUS_W-1:0] w_rx_head;

  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_snap;
  logic [BYTE_BUS_W-1:0] r_din;
  logic                  r_io_sel;
  logic                  r_halt;

  assign w_port   = decode_port(bus.cpu_a);
  assign w_rd     = (w_port != PORT_NONE) && !bus.cpu_wr;
  assign w_wr_req = (w_port != PORT_NONE) && bus.cpu_wr && !r_halt;

  // The stop write force-pushes 0x00; console writes of 0x00 are filtered out.
  assign w_tx_push_req = w_wr_req &&
                         ((w_port == PORT_COUNTER) || (bus.cpu_dout != '0));
  assign w_tx_din      = (w_port == PORT_COUNTER) ? '0 : bus.cpu_dout;
  assign w_tx_pop      = !w_tx_empty && bus.tx_ready;
  assign w_stall       = w_tx_push_req && w_tx_full && !w_tx_pop;
  assign w_tx_push     = w_tx_push_req && !w_stall;

  assign w_rx_push = bus.rx_valid && !w_rx_full;
  assign w_rx_pop  = w_rd && (w_port == PORT_CONSOLE) && !w_rx_empty;

  fifo_sync #(.W(BYTE_BUS_W), .AW(FIFO_AW)) u_rx_fifo (
    .clk     (clock),
    .rst     (reset),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_din   (bus.rx_data),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_head  (w_rx_head)
  );

  fifo_sync #(.W(BYTE_BUS_W), .AW(FIFO_AW)) u_tx_fifo (
    .clk     (clock),
    .rst     (reset),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_din   (w_tx_din),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_head  (w_tx_head)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_halt <= 1'b0;
    end else begin
      if (!r_halt) r_cnt <= r_cnt + 1'b1;
      if (w_wr_req && (w_port == PORT_COUNTER) && !w_stall) r_halt <= 1'b1;
    end
  end

  // Byte 0 of the counter port latches the snapshot; bytes 1..3 come from it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_din    <= '0;
      r_io_sel <= 1'b0;
      r_snap   <= '0;
    end else begin
      r_io_sel <= w_rd;
      if (w_rd && (w_port == PORT_CONSOLE)) begin
        r_din <= w_rx_head;
      end else if (w_rd && (w_port == PORT_COUNTER)) begin
        if (bus.cpu_a[1:0] == 2'd0) begin
          r_snap <= r_cnt;
          r_din  <= r_cnt[7:0];
        end else begin
          r_din  <= dword_byte(r_snap, bus.cpu_a[1:0]);
        end
      end
    end
  end

  assign bus.cpu_din  = r_din;
  assign bus.cpu_rdy  = !w_stall;
  assign bus.io_sel_q = r_io_sel;
  assign bus.rx_ready = !w_rx_full;
  assign bus.tx_valid = !w_tx_empty;
  assign bus.tx_data  = w_tx_head;
  assign bus.halt     = r_halt;

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_io_responder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_io_responder_if bus();

  mem_io_responder #(.FIFO_AW(3), .CNT_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit rnd_uart = 1'b0;

  // Reference model state
  logic [7:0]  m_rx[$];
  logic [7:0]  m_tx[$];
  logic [31:0] m_cnt   = 32'd0;
  logic [31:0] m_snap  = 32'd0;
  bit          m_halt  = 1'b0;
  bit          m_iosel = 1'b0;
  logic [7:0]  m_din   = 8'h00;
  logic [7:0]  tx_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_stall();
    bit io, req, pop;
    io  = (bus.cpu_a[17:16] == 2'b11);
    req = io && bus.cpu_wr && !m_halt && (bus.cpu_a[2] || (bus.cpu_dout != 8'h00));
    pop = (m_tx.size() > 0) && bus.tx_ready;
    return req && (m_tx.size() == 8) && !pop;
  endfunction

  // Model update: same edge the DUT samples on
  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      m_rx.delete(); m_tx.delete();
      m_cnt = 0; m_snap = 0; m_halt = 0; m_iosel = 0; m_din = 0;
    end else begin
      bit io, p4, rd, txpop, req, acc, rxpush;
      io     = (bus.cpu_a[17:16] == 2'b11);
      p4     = bus.cpu_a[2];
      rd     = io && !bus.cpu_wr;
      txpop  = (m_tx.size() > 0) && bus.tx_ready;
      req    = io && bus.cpu_wr && !m_halt && (p4 || (bus.cpu_dout != 8'h00));
      acc    = req && ((m_tx.size() < 8) || txpop);
      rxpush = bus.rx_valid && (m_rx.size() < 8);
      if (rd && !p4) m_din = (m_rx.size() > 0) ? m_rx.pop_front() : 8'h00;
      if (rd && p4) begin
        if (bus.cpu_a[1:0] == 2'd0) begin
          m_snap = m_cnt;
          m_din  = m_cnt[7:0];
        end else begin
          m_din = 8'(m_snap >> (8 * int'(bus.cpu_a[1:0])));
        end
      end
      m_iosel = rd;
      if (rxpush) m_rx.push_back(bus.rx_data);
      if (txpop) void'(m_tx.pop_front());
      if (acc) m_tx.push_back(p4 ? 8'h00 : bus.cpu_dout);
      if (!m_halt) m_cnt = m_cnt + 1;
      if (acc && p4) m_halt = 1'b1;
    end
  end

  // UART-side observer of what actually leaves the TX FIFO
  initial forever begin
    @(posedge clock);
    if (!reset && bus.tx_valid && bus.tx_ready) tx_log.push_back(bus.tx_data);
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clock);
    chk("cpu_din",  32'(bus.cpu_din),  32'(m_din));
    chk("io_sel_q", 32'(bus.io_sel_q), 32'(m_iosel));
    chk("halt",     32'(bus.halt),     32'(m_halt));
    chk("tx_valid", 32'(bus.tx_valid), 32'(m_tx.size() > 0));
    chk("tx_data",  32'(bus.tx_data),  32'((m_tx.size() > 0) ? m_tx[0] : 8'h00));
    chk("rx_ready", 32'(bus.rx_ready), 32'(m_rx.size() < 8));
    chk("cpu_rdy",  32'(bus.cpu_rdy),  32'(!m_stall()));
  end

  task automatic set_idle();
    bus.cpu_a = 18'h00000; bus.cpu_wr = 1'b0; bus.cpu_dout = 8'h00;
  endtask

  // One CPU bus transaction, held while cpu_rdy is low
  task automatic cyc(input logic [17:0] a, input bit wr, input logic [7:0] d);
    int n;
    bit rdy;
    n = 0;
    bus.cpu_a = a; bus.cpu_wr = wr; bus.cpu_dout = d;
    do begin
      if (rnd_uart) begin
        bus.rx_valid = 1'($urandom_range(0, 1));
        bus.rx_data  = 8'($urandom);
        bus.tx_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clock);
      rdy = bus.cpu_rdy;
      @(posedge clock); #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      n_tests++; n_fail++;
      $display("FAIL stall_timeout: cpu_rdy still 0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(18'h00000, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    set_idle();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    tx_log.delete();
  endtask

  initial begin
    int guard;
    set_idle();
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_cpu_rdy",  32'(bus.cpu_rdy),  32'd1);
    chk("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("reset_rx_ready", 32'(bus.rx_ready), 32'd1);
    reset = 1'b0;

    // Counter starts at zero and steps by one per clock
    cyc(18'h30004, 1'b0, 8'h00); chk("cnt_first", 32'(bus.cpu_din), 32'h00);
    chk("io_sel_after_read", 32'(bus.io_sel_q), 32'd1);
    cyc(18'h30004, 1'b0, 8'h00); chk("cnt_second", 32'(bus.cpu_din), 32'h01);
    cyc(18'h30004, 1'b0, 8'h00); chk("cnt_third", 32'(bus.cpu_din), 32'h02);

    // Console output with zero filtering
    bus.tx_ready = 1'b1;
    tx_log.delete();
    cyc(18'h30000, 1'b1, 8'h41);
    cyc(18'h30000, 1'b1, 8'h00);
    cyc(18'h30000, 1'b1, 8'h42);
    idle(4);
    chk("tx_out_count", 32'(tx_log.size()), 32'd2);
    if (tx_log.size() == 2) begin
      chk("tx_out_0", 32'(tx_log[0]), 32'h41);
      chk("tx_out_1", 32'(tx_log[1]), 32'h42);
    end

    // Console input
    bus.rx_valid = 1'b1; bus.rx_data = 8'h55; idle(1);
    bus.rx_data = 8'hAA; idle(1);
    bus.rx_valid = 1'b0;
    cyc(18'h30000, 1'b0, 8'h00); chk("rx_read_0", 32'(bus.cpu_din), 32'h55);
    cyc(18'h30000, 1'b0, 8'h00); chk("rx_read_1", 32'(bus.cpu_din), 32'hAA);
    cyc(18'h30000, 1'b0, 8'h00); chk("rx_read_empty", 32'(bus.cpu_din), 32'h00);
    idle(1); chk("io_sel_nonio", 32'(bus.io_sel_q), 32'd0);

    // TX back-pressure: ninth write stalls until the UART drains a byte
    bus.tx_ready = 1'b0;
    tx_log.delete();
    for (int i = 1; i <= 8; i++) cyc(18'h30000, 1'b1, 8'(i));
    bus.cpu_a = 18'h30000; bus.cpu_wr = 1'b1; bus.cpu_dout = 8'h09;
    @(negedge clock); chk("bp_rdy_low_0", 32'(bus.cpu_rdy), 32'd0);
    @(posedge clock); #1;
    @(negedge clock); chk("bp_rdy_low_1", 32'(bus.cpu_rdy), 32'd0);
    @(posedge clock); #1;
    bus.tx_ready = 1'b1;
    @(negedge clock); chk("bp_rdy_with_pop", 32'(bus.cpu_rdy), 32'd1);
    @(posedge clock); #1;
    set_idle();
    idle(12);
    chk("bp_count", 32'(tx_log.size()), 32'd9);
    if (tx_log.size() == 9)
      for (int i = 0; i < 9; i++) chk("bp_order", 32'(tx_log[i]), 32'(i + 1));

    // Halt: emits 0x00, freezes counter, ignores later writes
    tx_log.delete();
    cyc(18'h30004, 1'b1, 8'h5A);
    chk("halt_set", 32'(bus.halt), 32'd1);
    idle(3);
    chk("halt_tx_count", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() == 1) chk("halt_tx_zero", 32'(tx_log[0]), 32'h00);
    idle(5);
    cyc(18'h30004, 1'b0, 8'h00); chk("cnt_frozen", 32'(bus.cpu_din), 32'(m_cnt[7:0]));
    cyc(18'h30000, 1'b1, 8'h41);
    idle(3);
    chk("halt_blocks_write", 32'(tx_log.size()), 32'd1);

    // Asynchronous reset with bytes pending in TX and halt set
    do_reset();
    bus.tx_ready = 1'b0;
    cyc(18'h30000, 1'b1, 8'h11);
    cyc(18'h30000, 1'b1, 8'h22);
    cyc(18'h30000, 1'b1, 8'h33);
    cyc(18'h30004, 1'b1, 8'h00);
    chk("pre_rst_tx_valid", 32'(bus.tx_valid), 32'd1);
    chk("pre_rst_halt", 32'(bus.halt), 32'd1);
    set_idle();
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("async_rst_halt", 32'(bus.halt), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    tx_log.delete();
    cyc(18'h30004, 1'b0, 8'h00); chk("cnt_after_rst_0", 32'(bus.cpu_din), 32'h00);
    cyc(18'h30004, 1'b0, 8'h00); chk("cnt_after_rst_1", 32'(bus.cpu_din), 32'h01);

    // Snapshot coherence across the 0xFF -> 0x100 carry
    guard = 0;
    while (m_cnt != 32'h000000FF && guard < 400) begin
      idle(1);
      guard++;
    end
    chk("coh_reach_ff", 32'(guard < 400), 32'd1);
    cyc(18'h30004, 1'b0, 8'h00); chk("coh_b0", 32'(bus.cpu_din), 32'hFF);
    cyc(18'h30005, 1'b0, 8'h00); chk("coh_b1", 32'(bus.cpu_din), 32'h00);
    cyc(18'h30006, 1'b0, 8'h00); chk("coh_b2", 32'(bus.cpu_din), 32'h00);
    cyc(18'h30007, 1'b0, 8'h00); chk("coh_b3", 32'(bus.cpu_din), 32'h00);

    // Randomized traffic, periodically reset so halt does not dominate
    do_reset();
    rnd_uart = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int k;
      logic [17:0] a;
      bit wr;
      logic [7:0] d;
      if (i % 700 == 699) do_reset();
      k  = $urandom_range(0, 99);
      a  = {2'b11, 13'($urandom), 3'b000};
      wr = 1'b0;
      d  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      if (k < 40) begin
        a[2] = 1'b0;
      end else if (k < 65) begin
        a[2] = 1'b1; a[1:0] = 2'($urandom);
      end else if (k < 94) begin
        a[2] = 1'b0; a[1:0] = 2'($urandom); wr = 1'b1;
      end else if (k < 99) begin
        a = 18'($urandom);
        a[17:16] = 2'($urandom_range(0, 2));
        wr = 1'($urandom_range(0, 1));
      end else begin
        a[2] = 1'b1; wr = 1'b1;
      end
      cyc(a, wr, d);
    end
    rnd_uart = 1'b0;
    bus.rx_valid = 1'b0;
    set_idle();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
